// File: rtl/button_debounce2.sv
// Two-channel push-button synchronizer and debouncer with one-clock press/release pulses.
// Each channel feeds a clean, clock-aligned level to the downstream two-input logic stage.

module button_debounce2_chan #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic {
    IDLE,
    COUNT
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 db_q, db_d;
  logic                 rise_q, fall_q;
  logic                 sync1_q, sync2_q;
  logic                 p;

  assign p = ACTIVE_LOW ? ~btn : btn;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= p;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      rise_q  <= db_d & ~db_q;
      fall_q  <= ~db_d & db_q;
    end
  end

  // NOTE: every next-state signal gets a default first so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    case (state_q)
      IDLE: begin
        if (sync2_q != db_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            db_d = sync2_q;
          end else begin
            state_d = COUNT;
            cnt_d   = CNT_ONE;
          end
        end
      end
      COUNT: begin
        if (sync2_q == db_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          db_d    = sync2_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign db   = db_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

module button_debounce2 #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_a,
  input  logic btn_b,
  output logic a_db,
  output logic b_db,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  button_debounce2_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ACTIVE_LOW     (ACTIVE_LOW)
  ) u_chan_a (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_a),
    .db   (a_db),
    .rise (a_rise),
    .fall (a_fall)
  );

  button_debounce2_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ACTIVE_LOW     (ACTIVE_LOW)
  ) u_chan_b (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_b),
    .db   (b_db),
    .rise (b_rise),
    .fall (b_fall)
  );

endmodule

// File: tb/tb_button_debounce2.sv
// Directed bench for button_debounce2 with DEBOUNCE_CYCLES=4, ACTIVE_LOW=1.
// A change is accepted on the 6th rising edge counting the edge that first samples it.

module tb_button_debounce2;

  localparam int unsigned DC = 4;
  localparam int          LAT = 6;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_a, btn_b;
  logic a_db, b_db, a_rise, a_fall, b_rise, b_fall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  button_debounce2 #(
    .DEBOUNCE_CYCLES(DC),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_a (btn_a),
    .btn_b (btn_b),
    .a_db  (a_db),
    .b_db  (b_db),
    .a_rise(a_rise),
    .a_fall(a_fall),
    .b_rise(b_rise),
    .b_fall(b_fall)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] chan_of(input bit ch);
    return ch ? {b_db, b_rise, b_fall} : {a_db, a_rise, a_fall};
  endfunction

  // Input already changed; expect the new level exactly on edge LAT with one pulse.
  task automatic expect_accept(input bit ch, input logic val, input string tag);
    logic [2:0] old_st;
    logic [2:0] new_st;
    old_st = {~val, 2'b00};
    new_st = {val, val, ~val};
    for (int i = 1; i < LAT; i++) begin
      step();
      check({tag, "_hold"}, {5'd0, chan_of(ch)}, {5'd0, old_st});
    end
    step();
    check({tag, "_edge"}, {5'd0, chan_of(ch)}, {5'd0, new_st});
    step();
    check({tag, "_after"}, {5'd0, chan_of(ch)}, {5'd0, val, 2'b00});
  endtask

  initial begin
    // 1: reset with buttons idle
    rst_n = 1'b0;
    btn_a = 1'b1;
    btn_b = 1'b1;
    #12;
    check("rst_outputs", {2'd0, a_db, b_db, a_rise, a_fall, b_rise, b_fall}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("idle_outputs", {2'd0, a_db, b_db, a_rise, a_fall, b_rise, b_fall}, 8'h00);

    // 2: clean press on A
    btn_a = 1'b0;
    expect_accept(1'b0, 1'b1, "press_a");
    check("press_a_b_quiet", {7'd0, b_db}, 8'h00);

    // 3: bouncing B, two clocks per level, then held pressed
    for (int k = 0; k < 4; k++) begin
      btn_b = k[0];
      for (int i = 0; i < 2; i++) begin
        step();
        check("bounce_b", {6'd0, b_db, b_rise}, 8'h00);
      end
    end
    btn_b = 1'b0;
    expect_accept(1'b1, 1'b1, "settle_b");

    // 5: both pressed, downstream AND, then simultaneous release
    check("and_both", {7'd0, a_db & b_db}, 8'h01);
    btn_a = 1'b1;
    btn_b = 1'b1;
    for (int i = 1; i < LAT; i++) begin
      step();
      check("rel_hold", {2'd0, a_db, b_db, a_rise, a_fall, b_rise, b_fall}, 8'b0011_0000);
    end
    step();
    check("rel_edge", {2'd0, a_db, b_db, a_rise, a_fall, b_rise, b_fall}, 8'b0000_0101);
    step();
    check("rel_after", {2'd0, a_db, b_db, a_rise, a_fall, b_rise, b_fall}, 8'h00);
    check("and_released", {7'd0, a_db & b_db}, 8'h00);

    // 4: glitch on A sampled by only three edges
    btn_a = 1'b0;
    for (int i = 0; i < 3; i++) step();
    btn_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("glitch_a", {6'd0, a_db, a_rise}, 8'h00);
    end

    // 6: reset asserted with A's count at 2, button held throughout
    btn_a = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    #1;
    check("midrst_db", {6'd0, a_db, a_rise}, 8'h00);
    step();
    step();
    check("midrst_held", {6'd0, a_db, a_rise}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    expect_accept(1'b0, 1'b1, "repress_a");

    // Asynchronous clear of an accepted level without a clock edge
    rst_n = 1'b0;
    #1;
    check("async_clear", {7'd0, a_db}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
